// File: rtl/cla8_adder_unit.sv
// cla8_adder_unit: registered two-level carry-lookahead adder.
//
// Pipeline: operand capture register -> CLA -> result register.
// Operands captured at edge k appear on s/cout/prop/gen with out_valid
// after edge k+1. One operation per clock, no backpressure.
//
// Handshake: valid-only, no ready. in_valid=1 at a rising edge captures
// a/b/cin unconditionally. out_valid is a one-cycle pulse marking a fresh
// result. When out_valid=0 the result fields hold their last value.
//
// Optional build macro CLA_CHECK_EN: when defined, a comparator checks every
// registered result against a behavioural a+b+cin reference and drives the
// sticky err flag and the saturating err_count. When undefined both are 0.
// The adder datapath and its timing are the same in both builds.
//
// N must be a multiple of 4 in 4..32; each nibble is one 4-bit CLA group.

module cla8_adder_unit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         prop,
  output logic         gen,
  output logic         out_valid,
  output logic         err,
  output logic [15:0]  err_count
);

  localparam int NG = N / 4;

  // Stage 1 registers
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         cin_q;
  logic         v_q;

  // Combinational CLA signals
  logic [N-1:0]  p_bit;
  logic [N-1:0]  g_bit;
  logic [N-1:0]  carry_bit;
  logic [N-1:0]  sum_c;
  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_g;
  logic [NG:0]   grp_c;
  logic          cout_c;
  logic          prop_c;
  logic          gen_c;

  // Capture operands on in_valid; a reset discards whatever was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
      end
    end
  end

  // Bit-level propagate and generate.
  always_comb begin
    p_bit = a_q ^ b_q;
    g_bit = a_q & b_q;
  end

  // Group propagate/generate for each nibble.
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < NG; j++) begin
      grp_p[j] = p_bit[4*j] & p_bit[4*j+1] & p_bit[4*j+2] & p_bit[4*j+3];
      grp_g[j] = g_bit[4*j+3]
               | (p_bit[4*j+3] & g_bit[4*j+2])
               | (p_bit[4*j+3] & p_bit[4*j+2] & g_bit[4*j+1])
               | (p_bit[4*j+3] & p_bit[4*j+2] & p_bit[4*j+1] & g_bit[4*j]);
    end
  end

  // Second-level lookahead: each nibble carry-in is a flat sum of products
  // over the lower groups (no group-to-group ripple). The block generate is
  // the same expression for the top carry with the cin term dropped.
  always_comb begin
    logic c_acc;
    logic term;
    grp_c    = '0;
    grp_c[0] = cin_q;
    gen_c    = 1'b0;
    for (int j = 1; j <= NG; j++) begin
      c_acc = 1'b0;
      for (int k = 0; k < j; k++) begin
        term = grp_g[k];
        for (int m = k + 1; m < j; m++) begin
          term = term & grp_p[m];
        end
        c_acc = c_acc | term;
      end
      if (j == NG) begin
        gen_c = c_acc;
      end
      term = cin_q;
      for (int m = 0; m < j; m++) begin
        term = term & grp_p[m];
      end
      grp_c[j] = c_acc | term;
    end
    prop_c = &grp_p;
    cout_c = grp_c[NG];
  end

  // Lookahead carries inside each nibble, then the sum bits.
  always_comb begin
    logic c0;
    carry_bit = '0;
    for (int j = 0; j < NG; j++) begin
      c0 = grp_c[j];
      carry_bit[4*j]   = c0;
      carry_bit[4*j+1] = g_bit[4*j] | (p_bit[4*j] & c0);
      carry_bit[4*j+2] = g_bit[4*j+1]
                       | (p_bit[4*j+1] & g_bit[4*j])
                       | (p_bit[4*j+1] & p_bit[4*j] & c0);
      carry_bit[4*j+3] = g_bit[4*j+2]
                       | (p_bit[4*j+2] & g_bit[4*j+1])
                       | (p_bit[4*j+2] & p_bit[4*j+1] & g_bit[4*j])
                       | (p_bit[4*j+2] & p_bit[4*j+1] & p_bit[4*j] & c0);
    end
    sum_c = p_bit ^ carry_bit;
  end

  // Register the result when stage 1 holds valid operands; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      prop      <= 1'b0;
      gen       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v_q;
      if (v_q) begin
        s    <= sum_c;
        cout <= cout_c;
        prop <= prop_c;
        gen  <= gen_c;
      end
    end
  end

`ifdef CLA_CHECK_EN
  logic [N:0] ref_sum;
  logic [N:0] ref_nocin;
  logic       ref_prop;
  logic       mismatch;

  // Behavioural reference for the operands currently in stage 1.
  always_comb begin
    ref_sum   = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};
    ref_nocin = {1'b0, a_q} + {1'b0, b_q};
    ref_prop  = &(a_q ^ b_q);
    mismatch  = ({cout_c, sum_c} != ref_sum)
              | (prop_c != ref_prop)
              | (gen_c != ref_nocin[N]);
  end

  // Sticky error flag and saturating counter, updated as the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= 16'h0000;
    end else if (v_q && mismatch) begin
      err <= 1'b1;
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`else
  assign err       = 1'b0;
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cla8_adder_unit.sv
// Testbench for cla8_adder_unit: directed test-plan steps followed by
// randomized traffic, checked against an arithmetic reference model.

module tb_cla8_adder_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        cin;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  s;
  logic        cout;
  logic        prop;
  logic        gen;
  logic        out_valid;
  logic        err;
  logic [15:0] err_count;

  int cmp_count;
  int mismatches;

  // Scoreboard: results for captured operands not yet presented.
  // Packing is {cout, s[7:0], prop, gen}.
  logic [10:0] exp_q[$];
  logic [10:0] exp_res;
  logic        exp_ov;

  cla8_adder_unit #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .s         (s),
    .cout      (cout),
    .prop      (prop),
    .gen       (gen),
    .out_valid (out_valid),
    .err       (err),
    .err_count (err_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands.
  function automatic logic [10:0] ref_result(input logic [7:0] x, input logic [7:0] y,
                                             input logic c);
    logic [8:0] full;
    logic [8:0] nocin;
    full  = {1'b0, x} + {1'b0, y} + {8'h00, c};
    nocin = {1'b0, x} + {1'b0, y};
    return {full[8], full[7:0], &(x ^ y), nocin[8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    cmp_count++;
    assert (got === want)
      else begin
        mismatches++;
        $error("FAIL %s: observed=%h expected=%h", tag, got, want);
      end
  endtask

  // Driver: one clock with the given inputs, model update, then checks.
  task automatic cycle(input logic r, input logic v, input logic [7:0] aa,
                       input logic [7:0] bb, input logic c);
    rst      = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = c;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_ov  = 1'b0;
      exp_res = '0;
    end else begin
      exp_ov = (exp_q.size() > 0);
      if (exp_ov) exp_res = exp_q.pop_front();
      if (v) exp_q.push_back(ref_result(aa, bb, c));
    end
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    chk("result", {21'd0, cout, s, prop, gen}, {21'd0, exp_res});
    chk("err", {31'd0, err}, 32'd0);
    chk("err_count", {16'd0, err_count}, 32'd0);
    chk("prop_gen_excl", {31'd0, prop & gen}, 32'd0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] corners [6];
    cmp_count  = 0;
    mismatches = 0;
    exp_ov     = 1'b0;
    exp_res    = '0;
    corners    = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};

    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_s", {24'd0, s}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    chk("reset_prop", {31'd0, prop}, 32'd0);
    chk("reset_gen", {31'd0, gen}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_err_count", {16'd0, err_count}, 32'd0);

    // 00 + 00 + 0: result two cycles after the drive.
    cycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    idle();
    chk("tp_zero_valid", {31'd0, out_valid}, 32'd1);
    chk("tp_zero", {21'd0, cout, s, prop, gen}, {21'd0, 1'b0, 8'h00, 1'b0, 1'b0});

    // Full propagate chain across both nibbles.
    cycle(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
    idle();
    chk("tp_ff00c1", {21'd0, cout, s, prop, gen}, {21'd0, 1'b1, 8'h00, 1'b1, 1'b0});

    cycle(1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
    idle();
    chk("tp_8080", {21'd0, cout, s, prop, gen}, {21'd0, 1'b1, 8'h00, 1'b0, 1'b1});
    cycle(1'b0, 1'b1, 8'h55, 8'hAA, 1'b0);
    idle();
    chk("tp_55aa", {21'd0, cout, s, prop, gen}, {21'd0, 1'b0, 8'hFF, 1'b1, 1'b0});
    idle();
    chk("tp_hold_valid", {31'd0, out_valid}, 32'd0);
    chk("tp_hold_s", {24'd0, s}, 32'h0000_00FF);

    // Back-to-back operations.
    cycle(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    cycle(1'b0, 1'b1, 8'h0F, 8'h01, 1'b0);
    chk("b2b_0", {23'd0, s, cout}, {23'd0, 8'h02, 1'b0});
    cycle(1'b0, 1'b1, 8'hF0, 8'h10, 1'b0);
    chk("b2b_1", {23'd0, s, cout}, {23'd0, 8'h10, 1'b0});
    cycle(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    chk("b2b_2", {23'd0, s, cout}, {23'd0, 8'h00, 1'b1});
    idle();
    chk("b2b_3", {23'd0, s, cout}, {23'd0, 8'hFF, 1'b1});
    chk("b2b_3_valid", {31'd0, out_valid}, 32'd1);

    // Reset with an operand in flight: no stale result afterwards.
    cycle(1'b0, 1'b1, 8'h12, 8'h34, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("rst_flight_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flight_out", {21'd0, cout, s, prop, gen}, 32'd0);
    idle();
    chk("rst_flight_no_stale", {31'd0, out_valid}, 32'd0);
    idle();

    // Exhaustive corners, back-to-back.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        for (int c = 0; c < 2; c++) begin
          cycle(1'b0, 1'b1, corners[i], corners[j], c[0]);
        end
      end
    end
    idle();

    // Random traffic with gaps and occasional resets.
    for (int n = 0; n < 30000; n++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
    end
    idle();
    idle();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mismatches);
    $finish;
  end

endmodule
